// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if -- write-request and RAM bus bundle for vram_arbiter.
//   req0/req1       : write requests, held with wAddrX/wDataX until gntX
//   wAddr0/wAddr1   : 15-bit frame-buffer write addresses
//   wData0/wData1   : 8-bit write data
//   gnt0/gnt1       : one-cycle write-accepted pulses
//   memAddr/memWData/memWE : single-port RAM command (read when memWE=0)
//   memRData        : RAM read data
// Modport slave is the arbiter's view; master is the requesters + RAM side.
interface vram_arbiter_if;
  logic        req0;
  logic        req1;
  logic [14:0] wAddr0;
  logic [14:0] wAddr1;
  logic [7:0]  wData0;
  logic [7:0]  wData1;
  logic        gnt0;
  logic        gnt1;
  logic [14:0] memAddr;
  logic [7:0]  memWData;
  logic        memWE;
  logic [7:0]  memRData;

  modport slave (
    input  req0, req1, wAddr0, wAddr1, wData0, wData1, memRData,
    output gnt0, gnt1, memAddr, memWData, memWE
  );

  modport master (
    output req0, req1, wAddr0, wAddr1, wData0, wData1, memRData,
    input  gnt0, gnt1, memAddr, memWData, memWE
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter -- shares one single-port frame-buffer RAM between the VGA
// display read path and two write requesters.
//   real100clock : 100 MHz system clock, rising edge
//   resetN       : asynchronous active-low reset
//   pixelTick    : pixel enable, every other clock
//   xPixel/yPixel: current scan position
//   VGAblanck    : high while horizontally inside the visible window
//   frameStart   : one-cycle pulse at the start of vertical blank
//   writeMode    : 0 = interleave writes, 1 = write only in vertical blank
//   bus          : request/grant and RAM signals (vram_arbiter_if.slave)
//   pixelColor   : colour to the DAC, one cycle after each display read
//   vblank       : high while the region tracker is in vertical blank
module vram_arbiter (
  input  logic        real100clock,
  input  logic        resetN,
  input  logic        pixelTick,
  input  logic [9:0]  xPixel,
  input  logic [8:0]  yPixel,
  input  logic        VGAblanck,
  input  logic        frameStart,
  input  logic        writeMode,
  vram_arbiter_if.slave bus,
  output logic [7:0]  pixelColor,
  output logic        vblank
);

  typedef enum logic {ACTIVE = 1'b0, VBLANK = 1'b1} region_t;

  region_t     regionReg, regionNext;
  logic [1:0]  reqVec;
  logic [1:0]  eligible;
  logic [1:0]  gntReg;
  logic        memWEReg;
  logic [14:0] wrAddrReg;
  logic [7:0]  wrDataReg;
  logic        rrPtrReg;      // 1 = req1 wins a tie
  logic [7:0]  pixelColorReg;

  logic        inWindow;
  logic        displaySlot;
  logic        preDisplay;
  logic        writeSlot;
  logic        issue;
  logic        pick1;
  logic [14:0] dispAddr;

  // 160x120 buffer shown 4x: drop the two LSBs of each coordinate.
  assign dispAddr    = {yPixel[8:2], xPixel[9:2]};
  assign inWindow    = VGAblanck && (xPixel < 10'd640) && (yPixel < 9'd480);
  assign displaySlot = pixelTick && inWindow;
  // A decision made now issues next cycle, so a cycle that precedes a
  // display slot must not decide anything.
  assign preDisplay  = !pixelTick && inWindow;
  assign writeSlot   = !displaySlot && (!writeMode || (regionReg == VBLANK));

  assign reqVec = {bus.req1, bus.req0};

  // A requester is masked while its grant is showing so a request still
  // held during that cycle is not granted twice.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign eligible[gi] = reqVec[gi] && !gntReg[gi];
    end
  endgenerate

  assign issue = writeSlot && !preDisplay && (eligible != 2'b00);
  assign pick1 = eligible[1] && (!eligible[0] || rrPtrReg);

  // Region tracker.
  always_ff @(posedge real100clock or negedge resetN) begin
    if (!resetN) begin
      regionReg <= ACTIVE;
    end else begin
      regionReg <= regionNext;
    end
  end

  always_comb begin
    regionNext = regionReg;
    case (regionReg)
      ACTIVE:  if (frameStart)                      regionNext = VBLANK;
      VBLANK:  if ((yPixel == 9'd0) && pixelTick)   regionNext = ACTIVE;
      default:                                      regionNext = ACTIVE;
    endcase
  end

  // Registered write issue and display read capture.
  always_ff @(posedge real100clock or negedge resetN) begin
    if (!resetN) begin
      gntReg        <= 2'b00;
      memWEReg      <= 1'b0;
      wrAddrReg     <= '0;
      wrDataReg     <= '0;
      rrPtrReg      <= 1'b0;
      pixelColorReg <= '0;
    end else begin
      gntReg        <= issue ? (pick1 ? 2'b10 : 2'b01) : 2'b00;
      memWEReg      <= issue;
      wrAddrReg     <= issue ? (pick1 ? bus.wAddr1 : bus.wAddr0) : '0;
      wrDataReg     <= issue ? (pick1 ? bus.wData1 : bus.wData0) : '0;
      if (issue) begin
        rrPtrReg <= !pick1;   // next tie goes to the other requester
      end
      pixelColorReg <= displaySlot ? bus.memRData : 8'h00;
    end
  end

  assign bus.gnt0     = gntReg[0];
  assign bus.gnt1     = gntReg[1];
  assign bus.memWE    = memWEReg;
  assign bus.memWData = wrDataReg;
  // resetN gates the combinational display address so memAddr reads 0
  // while reset is held.
  assign bus.memAddr  = memWEReg ? wrAddrReg :
                        ((displaySlot && resetN) ? dispAddr : 15'd0);
  assign pixelColor   = pixelColorReg;
  assign vblank       = (regionReg == VBLANK);

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
  logic       real100clock = 1'b0;
  logic       resetN = 1'b0;
  logic       pixelTick = 1'b0;
  logic [9:0] xPixel = '0;
  logic [8:0] yPixel = '0;
  logic       VGAblanck = 1'b0;
  logic       frameStart = 1'b0;
  logic       writeMode = 1'b0;
  logic [7:0] pixelColor;
  logic       vblank;

  vram_arbiter_if bus();

  vram_arbiter dut (
    .real100clock(real100clock),
    .resetN(resetN),
    .pixelTick(pixelTick),
    .xPixel(xPixel),
    .yPixel(yPixel),
    .VGAblanck(VGAblanck),
    .frameStart(frameStart),
    .writeMode(writeMode),
    .bus(bus),
    .pixelColor(pixelColor),
    .vblank(vblank)
  );

  always #5 real100clock = ~real100clock;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h required %0h", name, act, exp);
    else passed++;
  endtask

  task automatic nextCycle();
    @(negedge real100clock);
    pixelTick = ~pixelTick;
  endtask

  task automatic toVblank();
    nextCycle(); frameStart = 1'b1; yPixel = 9'd480; VGAblanck = 1'b0; xPixel = 10'd700;
    nextCycle(); frameStart = 1'b0;
    #1 chk("to_vblank", 32'(vblank), 1);
  endtask

  task automatic toActive();
    yPixel = 9'd0; VGAblanck = 1'b0; xPixel = 10'd700;
    repeat (2) nextCycle();
    nextCycle(); yPixel = 9'd100;
    #1 chk("to_active", 32'(vblank), 0);
  endtask

  typedef struct {
    logic        tick;
    logic        blank;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [7:0]  rData;
    logic        disp;
    logic [14:0] addr;
    logic [7:0]  color;
  } vec_t;

  vec_t vecs[8];

  // reference model state for the random phase
  bit          pend[2];
  bit [14:0]   pAddr[2];
  bit [7:0]    pData[2];
  bit [1:0]    expGnt;
  bit          expWe;
  bit [14:0]   expAddr;
  bit [7:0]    expData;
  bit [7:0]    expColor;
  bit          inVb;
  int          lastWin;

  initial begin
    bit seen0, seen1, disp, preDisp, canWrite, want0, want1;
    bit [1:0] nGnt;
    int w, dispAddr;

    vecs[0] = '{1'b1, 1'b1, 10'd8,   9'd4,   8'hA5, 1'b1, 15'h0102, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 10'd639, 9'd479, 8'h3C, 1'b1, 15'h779F, 8'h3C};
    vecs[2] = '{1'b1, 1'b1, 10'd0,   9'd0,   8'h7E, 1'b1, 15'h0000, 8'h7E};
    vecs[3] = '{1'b1, 1'b1, 10'd100, 9'd200, 8'h11, 1'b1, 15'h3219, 8'h11};
    vecs[4] = '{1'b1, 1'b1, 10'd640, 9'd10,  8'h22, 1'b0, 15'h0000, 8'h00};
    vecs[5] = '{1'b1, 1'b1, 10'd10,  9'd480, 8'h33, 1'b0, 15'h0000, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 10'd10,  9'd10,  8'h44, 1'b0, 15'h0000, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 10'd10,  9'd10,  8'h55, 1'b0, 15'h0000, 8'h00};

    bus.req0 = 0; bus.req1 = 0; bus.wAddr0 = '0; bus.wAddr1 = '0;
    bus.wData0 = '0; bus.wData1 = '0; bus.memRData = '0;

    // reset state
    repeat (3) @(negedge real100clock);
    #1;
    chk("rst_gnt0", 32'(bus.gnt0), 0);
    chk("rst_gnt1", 32'(bus.gnt1), 0);
    chk("rst_memWE", 32'(bus.memWE), 0);
    chk("rst_memAddr", 32'(bus.memAddr), 0);
    chk("rst_memWData", 32'(bus.memWData), 0);
    chk("rst_pixelColor", 32'(pixelColor), 0);
    chk("rst_vblank", 32'(vblank), 0);
    @(negedge real100clock); resetN = 1'b1;

    // display read vectors
    for (int i = 0; i < 8; i++) begin
      @(negedge real100clock);
      pixelTick = vecs[i].tick; VGAblanck = vecs[i].blank;
      xPixel = vecs[i].x; yPixel = vecs[i].y; bus.memRData = vecs[i].rData;
      #1;
      if (vecs[i].disp) chk($sformatf("vec%0d_memAddr", i), 32'(bus.memAddr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_memWE", i), 32'(bus.memWE), 0);
      @(negedge real100clock);
      pixelTick = ~pixelTick; VGAblanck = 1'b0; bus.memRData = 8'hEE;
      #1 chk($sformatf("vec%0d_pixelColor", i), 32'(pixelColor), 32'(vecs[i].color));
    end

    // contention in vertical blank, interleaved mode
    toVblank();
    writeMode = 1'b0; yPixel = 9'd490;
    bus.req0 = 1; bus.wAddr0 = 15'h1111; bus.wData0 = 8'h11;
    bus.req1 = 1; bus.wAddr1 = 15'h2222; bus.wData1 = 8'h22;
    seen0 = 0; seen1 = 0;
    for (int c = 0; c < 10 && !seen1; c++) begin
      nextCycle(); #1;
      if (bus.gnt0 && !seen0) begin
        seen0 = 1;
        $display("txn gnt0 addr=%h data=%h", bus.memAddr, bus.memWData);
        chk("cont_gnt1_not_with_gnt0", 32'(bus.gnt1), 0);
        chk("cont_memWE0", 32'(bus.memWE), 1);
        chk("cont_memAddr0", 32'(bus.memAddr), 32'h1111);
        chk("cont_memWData0", 32'(bus.memWData), 32'h11);
        bus.req0 = 0;
      end else if (bus.gnt1) begin
        seen1 = 1;
        $display("txn gnt1 addr=%h data=%h", bus.memAddr, bus.memWData);
        chk("cont_gnt0_first", 32'(seen0), 1);
        chk("cont_memAddr1", 32'(bus.memAddr), 32'h2222);
        chk("cont_memWData1", 32'(bus.memWData), 32'h22);
        bus.req1 = 0;
      end
    end
    chk("cont_gnt1_seen", 32'(seen1), 1);
    bus.req0 = 0; bus.req1 = 0;

    // slot protection across the end of a visible line
    toActive();
    writeMode = 1'b0; yPixel = 9'd10; xPixel = 10'd630; VGAblanck = 1'b1;
    pixelTick = 1'b1;
    bus.req1 = 1; bus.wAddr1 = 15'h0666; bus.wData1 = 8'h66;
    seen1 = 0;
    for (int c = 0; c < 40 && !seen1; c++) begin
      nextCycle();
      if (!pixelTick) xPixel = xPixel + 10'd1;
      VGAblanck = (xPixel < 10'd640);
      #1;
      disp = pixelTick && VGAblanck && (xPixel < 10'd640);
      chk("slot_no_clash", 32'(bus.memWE && disp), 0);
      if (bus.gnt1) begin
        seen1 = 1;
        $display("txn gnt1 addr=%h data=%h x=%0d", bus.memAddr, bus.memWData, xPixel);
        chk("slot_gnt_outside_window", 32'(xPixel >= 10'd640), 1);
        chk("slot_memAddr", 32'(bus.memAddr), 32'h0666);
        chk("slot_memWData", 32'(bus.memWData), 32'h66);
        bus.req1 = 0;
      end
    end
    chk("slot_gnt1_seen", 32'(seen1), 1);
    bus.req1 = 0;

    // tear-free mode: request in the active region waits for frameStart
    VGAblanck = 1'b0; xPixel = 10'd700; yPixel = 9'd100;
    writeMode = 1'b1;
    bus.req0 = 1; bus.wAddr0 = 15'h0AAA; bus.wData0 = 8'h77;
    for (int c = 0; c < 20; c++) begin
      nextCycle(); #1 chk("tear_no_gnt_active", 32'(bus.gnt0), 0);
    end
    nextCycle(); frameStart = 1'b1; yPixel = 9'd480;
    #1 chk("tear_no_gnt_at_frameStart", 32'(bus.gnt0), 0);
    seen0 = 0;
    for (int c = 0; c < 2 && !seen0; c++) begin
      nextCycle(); frameStart = 1'b0; #1;
      if (bus.gnt0) begin
        seen0 = 1;
        $display("txn gnt0 addr=%h data=%h", bus.memAddr, bus.memWData);
        chk("tear_memWData", 32'(bus.memWData), 32'h77);
        bus.req0 = 0;
      end
    end
    chk("tear_gnt0_within_2", 32'(seen0), 1);
    bus.req0 = 0;

    // abandon: request dropped before the blank never writes
    toActive();
    writeMode = 1'b1;
    bus.req0 = 1; bus.wAddr0 = 15'h0BBB; bus.wData0 = 8'h88;
    for (int c = 0; c < 20; c++) begin
      nextCycle();
      if (c == 5) bus.req0 = 0;
      if (c == 10) begin frameStart = 1'b1; yPixel = 9'd480; end
      else frameStart = 1'b0;
      #1;
      chk("abandon_memWE", 32'(bus.memWE), 0);
      chk("abandon_gnt0", 32'(bus.gnt0), 0);
    end

    // reset while a grant is showing
    writeMode = 1'b0;
    bus.req0 = 1; bus.wAddr0 = 15'h0123; bus.wData0 = 8'h99;
    seen0 = 0;
    for (int c = 0; c < 6 && !seen0; c++) begin
      nextCycle(); #1;
      if (bus.gnt0) begin
        seen0 = 1;
        resetN = 1'b0; bus.req0 = 0;
        #1;
        chk("rstmid_memWE", 32'(bus.memWE), 0);
        chk("rstmid_gnt0", 32'(bus.gnt0), 0);
        chk("rstmid_pixelColor", 32'(pixelColor), 0);
        chk("rstmid_vblank", 32'(vblank), 0);
      end
    end
    chk("rstmid_gnt0_seen", 32'(seen0), 1);
    resetN = 1'b0;
    repeat (2) nextCycle();
    resetN = 1'b1;
    for (int c = 0; c < 8; c++) begin
      nextCycle(); #1 chk("rstmid_no_write_after", 32'(bus.memWE), 0);
    end
    bus.req0 = 1; bus.wAddr0 = 15'h0321; bus.wData0 = 8'h5A;
    seen0 = 0;
    for (int c = 0; c < 6 && !seen0; c++) begin
      nextCycle(); #1;
      if (bus.gnt0) begin
        seen0 = 1;
        $display("txn gnt0 addr=%h data=%h", bus.memAddr, bus.memWData);
        chk("rstmid_new_memAddr", 32'(bus.memAddr), 32'h0321);
        bus.req0 = 0;
      end
    end
    chk("rstmid_new_gnt0", 32'(seen0), 1);
    bus.req0 = 0;

    // randomized phase against the reference model
    nextCycle(); resetN = 1'b0; frameStart = 1'b0; writeMode = 1'b0;
    nextCycle(); resetN = 1'b1;
    pend[0] = 0; pend[1] = 0; expGnt = 0; expWe = 0; expAddr = 0; expData = 0;
    expColor = 0; inVb = 0; lastWin = 1;
    for (int c = 0; c < 2500; c++) begin
      @(negedge real100clock);
      for (int i = 0; i < 2; i++) begin
        if (expGnt[i]) pend[i] = 0;
        if (!pend[i] && $urandom_range(0, 99) < 30) begin
          pend[i] = 1; pAddr[i] = 15'($urandom); pData[i] = 8'($urandom);
        end else if (pend[i] && !expGnt[i] && $urandom_range(0, 99) < 2) begin
          pend[i] = 0;
        end
      end
      bus.req0 = pend[0]; bus.wAddr0 = pAddr[0]; bus.wData0 = pData[0];
      bus.req1 = pend[1]; bus.wAddr1 = pAddr[1]; bus.wData1 = pData[1];
      pixelTick = ~pixelTick;
      // scan position only moves between pixel pairs
      if (!pixelTick) begin
        VGAblanck = ($urandom_range(0, 99) < 75);
        xPixel = ($urandom_range(0, 99) < 80) ? 10'($urandom_range(0, 639)) : 10'($urandom_range(640, 799));
        w = $urandom_range(0, 99);
        yPixel = (w < 5) ? 9'd0 : (w < 80) ? 9'($urandom_range(0, 479)) : 9'($urandom_range(480, 524));
      end
      frameStart = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 2) writeMode = ~writeMode;
      bus.memRData = 8'($urandom);
      #1;
      disp = pixelTick && VGAblanck && (xPixel < 10'd640) && (yPixel < 9'd480);
      preDisp = !pixelTick && VGAblanck && (xPixel < 10'd640) && (yPixel < 9'd480);
      dispAddr = (int'(yPixel) / 4) * 256 + int'(xPixel) / 4;
      chk("rnd_gnt0", 32'(bus.gnt0), 32'(expGnt[0]));
      chk("rnd_gnt1", 32'(bus.gnt1), 32'(expGnt[1]));
      chk("rnd_memWE", 32'(bus.memWE), 32'(expWe));
      chk("rnd_pixelColor", 32'(pixelColor), 32'(expColor));
      chk("rnd_vblank", 32'(vblank), 32'(inVb));
      if (expWe) begin
        $display("txn gnt%0d addr=%h data=%h", expGnt[1] ? 1 : 0, expAddr, expData);
        chk("rnd_memAddr_write", 32'(bus.memAddr), 32'(expAddr));
        chk("rnd_memWData", 32'(bus.memWData), 32'(expData));
      end else if (disp) begin
        chk("rnd_memAddr_display", 32'(bus.memAddr), dispAddr);
      end
      // model: what this cycle's inputs produce next cycle
      canWrite = !disp && !preDisp && (!writeMode || inVb);
      want0 = pend[0] && !expGnt[0];
      want1 = pend[1] && !expGnt[1];
      nGnt = 0; expWe = 0; expAddr = 0; expData = 0;
      if (canWrite && (want0 || want1)) begin
        if (want0 && want1) w = (lastWin == 0) ? 1 : 0;
        else w = want0 ? 0 : 1;
        lastWin = w;
        nGnt[w] = 1; expWe = 1; expAddr = pAddr[w]; expData = pData[w];
      end
      expGnt = nGnt;
      expColor = disp ? bus.memRData : 8'h00;
      if (!inVb && frameStart) inVb = 1;
      else if (inVb && yPixel == 9'd0 && pixelTick) inVb = 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
